up_tpl_profile_regs: RTL and testbench

UP_TPL_PROFILE_REGS -- requirements
Module: up_tpl_profile_regs

---
 rtl/up_tpl_profile_regs.sv | 135 +++++++++++++
 tb/tb_up_tpl_profile_regs.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/up_tpl_profile_regs.sv
// up_tpl_profile_regs: register bank for selecting the active datapath profile and reading its descriptor.
// Define TPL_PROFILE_HANDSHAKE_EN to gate profile changes through a req/ack handshake with the datapath.
module up_tpl_profile_regs #(
    parameter int NUM_PROFILES = 1
) (
    input  logic                       up_clk,
    input  logic                       up_rst,
    input  logic                       up_wreq,
    input  logic [13:0]                up_waddr,
    input  logic [31:0]                up_wdata,
    output logic                       up_wack,
    input  logic                       up_rreq,
    input  logic [13:0]                up_raddr,
    output logic [31:0]                up_rdata,
    output logic                       up_rack,
    input  logic [NUM_PROFILES*48-1:0] profile_desc,
    output logic [3:0]                 profile_sel,
    output logic                       profile_req,
    output logic [3:0]                 profile_req_sel,
    input  logic                       profile_ack
);
    localparam logic [13:0] A_CNTRL  = 14'h080;
    localparam logic [13:0] A_STATUS = 14'h081;
    localparam logic [13:0] A_DESC1  = 14'h090;
    localparam logic [13:0] A_DESC2  = 14'h091;
    localparam logic [4:0]  NP5      = 5'(NUM_PROFILES);
    localparam logic [3:0]  MAXSEL   = 4'(NUM_PROFILES - 1);

    logic        wack_q, rack_q;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  sel_reg_q, sel_reg_d, profile_sel_q, profile_sel_d;
    logic        wdec, rdec, wr_ok;
    logic [3:0]  wsel;
    logic [47:0] desc;
    logic [47:0] desc_a [16];
    logic        unused_bits;

    // Profiles beyond NUM_PROFILES read as zero; sel can never reach them anyway.
    for (genvar g = 0; g < 16; g++) begin : g_desc
        if (g < NUM_PROFILES) begin : g_on
            assign desc_a[g] = profile_desc[48*g +: 48];
        end else begin : g_off
            assign desc_a[g] = '0;
        end
    end

    assign desc  = desc_a[profile_sel_q];
    assign wsel  = up_wdata[3:0];
    assign wdec  = up_wreq && (up_waddr == A_CNTRL || up_waddr == A_STATUS ||
                               up_waddr == A_DESC1 || up_waddr == A_DESC2);
    assign rdec  = up_rreq && (up_raddr == A_CNTRL || up_raddr == A_STATUS ||
                               up_raddr == A_DESC1 || up_raddr == A_DESC2);
    assign wr_ok = up_wreq && up_waddr == A_CNTRL && {1'b0, wsel} < NP5;

    always_comb begin
        rdata_d = !rdec                 ? 32'h0 :
                  up_raddr == A_CNTRL   ? {28'h0, sel_reg_q} :
                  up_raddr == A_STATUS  ? {28'h0, MAXSEL} :
                  up_raddr == A_DESC1   ? desc[31:0] :
                                          {16'h0, desc[47:32]};
    end

`ifdef TPL_PROFILE_HANDSHAKE_EN
    typedef enum logic {IDLE, REQ} state_t;
    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic [3:0] req_sel_q, req_sel_d;

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        req_sel_d     = req_sel_q;
        sel_reg_d     = sel_reg_q;
        profile_sel_d = profile_sel_q;
        if (state_q == IDLE) begin
            if (wr_ok) begin
                sel_reg_d = wsel;
                if (wsel != profile_sel_q) begin
                    req_sel_d = wsel;
                    req_d     = 1'b1;
                    state_d   = REQ;
                end
            end
        end else if (profile_ack) begin
            profile_sel_d = req_sel_q;
            req_d         = 1'b0;
            state_d       = IDLE;
        end
    end

    assign profile_req     = req_q;
    assign profile_req_sel = req_sel_q;
    assign unused_bits     = ^up_wdata[31:4];
`else
    always_comb begin
        sel_reg_d     = wr_ok ? wsel : sel_reg_q;
        profile_sel_d = wr_ok ? wsel : profile_sel_q;
    end

    assign profile_req     = 1'b0;
    assign profile_req_sel = 4'h0;
    assign unused_bits     = ^{up_wdata[31:4], profile_ack};
`endif

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            wack_q        <= 1'b0;
            rack_q        <= 1'b0;
            rdata_q       <= '0;
            sel_reg_q     <= '0;
            profile_sel_q <= '0;
`ifdef TPL_PROFILE_HANDSHAKE_EN
            state_q       <= IDLE;
            req_q         <= 1'b0;
            req_sel_q     <= '0;
`endif
        end else begin
            wack_q        <= wdec;
            rack_q        <= rdec;
            rdata_q       <= rdata_d;
            sel_reg_q     <= sel_reg_d;
            profile_sel_q <= profile_sel_d;
`ifdef TPL_PROFILE_HANDSHAKE_EN
            state_q       <= state_d;
            req_q         <= req_d;
            req_sel_q     <= req_sel_d;
`endif
        end
    end

    assign up_wack     = wack_q;
    assign up_rack     = rack_q;
    assign up_rdata    = rdata_q;
    assign profile_sel = profile_sel_q;
endmodule

// File: tb/tb_up_tpl_profile_regs.sv
// tb_up_tpl_profile_regs: directed plus randomized register traffic checked against a register-level model.
module tb_up_tpl_profile_regs;
    localparam int NP = 4;

    logic           up_clk = 1'b0;
    logic           up_rst = 1'b1;
    logic           up_wreq = 1'b0, up_rreq = 1'b0, profile_ack = 1'b0;
    logic [13:0]    up_waddr = '0, up_raddr = '0;
    logic [31:0]    up_wdata = '0;
    logic [NP*48-1:0] profile_desc = '0;
    logic           up_wack, up_rack, profile_req;
    logic [31:0]    up_rdata;
    logic [3:0]     profile_sel, profile_req_sel;

    up_tpl_profile_regs #(.NUM_PROFILES(NP)) dut (
        .up_clk(up_clk), .up_rst(up_rst),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .profile_desc(profile_desc), .profile_sel(profile_sel),
        .profile_req(profile_req), .profile_req_sel(profile_req_sel), .profile_ack(profile_ack)
    );

    always #5 up_clk = ~up_clk;

    int          tests = 0, fails = 0;
    logic [47:0] desc [NP];
    logic [3:0]  m_sel = '0, m_psel = '0, m_rsel = '0;
    bit          m_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit decoded(input logic [13:0] a);
        return a == 14'h080 || a == 14'h081 || a == 14'h090 || a == 14'h091;
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        logic [47:0] d;
        d = desc[m_psel];
        if (a == 14'h080) return {28'h0, m_sel};
        if (a == 14'h081) return NP - 1;
        if (a == 14'h090) return d[31:0];
        if (a == 14'h091) return {16'h0, d[47:32]};
        return 32'h0;
    endfunction

    task automatic model_write(input logic [13:0] a, input logic [31:0] d);
        if (a != 14'h080 || d[3:0] >= NP) return;
`ifdef TPL_PROFILE_HANDSHAKE_EN
        if (m_pend) return;
        m_sel = d[3:0];
        if (d[3:0] != m_psel) begin
            m_pend = 1'b1;
            m_rsel = d[3:0];
        end
`else
        m_sel  = d[3:0];
        m_psel = d[3:0];
`endif
    endtask

    task automatic model_reset();
        m_sel = '0; m_psel = '0; m_rsel = '0; m_pend = 1'b0;
    endtask

    task automatic check_profile(input string tag);
        check({tag, " sel"}, 32'(profile_sel), 32'(m_psel));
        check({tag, " req"}, 32'(profile_req), 32'(m_pend));
        check({tag, " req_sel"}, 32'(profile_req_sel), 32'(m_rsel));
    endtask

    task automatic rd(input logic [13:0] a, input string tag);
        logic [31:0] e;
        e = m_read(a);
        @(negedge up_clk); up_rreq = 1'b1; up_raddr = a;
        @(negedge up_clk); up_rreq = 1'b0;
        check({tag, " rack"}, 32'(up_rack), 32'(decoded(a)));
        check({tag, " rdata"}, up_rdata, decoded(a) ? e : 32'h0);
        @(negedge up_clk);
        check({tag, " rack drop"}, {31'h0, up_rack} | up_rdata, 32'h0);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input string tag);
        @(negedge up_clk); up_wreq = 1'b1; up_waddr = a; up_wdata = d;
        @(negedge up_clk); up_wreq = 1'b0;
        model_write(a, d);
        check({tag, " wack"}, 32'(up_wack), 32'(decoded(a)));
        check_profile(tag);
    endtask

    // Hold off the ack for k cycles, checking the request stays stable, then complete it.
    task automatic ack_after(input int k, input string tag);
        repeat (k) begin
            check({tag, " hold req"}, 32'(profile_req), 32'(m_pend));
            check({tag, " hold req_sel"}, 32'(profile_req_sel), 32'(m_rsel));
            @(negedge up_clk);
        end
        profile_ack = 1'b1;
        @(negedge up_clk); profile_ack = 1'b0;
        if (m_pend) m_psel = m_rsel;
        m_pend = 1'b0;
        check_profile({tag, " acked"});
    endtask

    initial begin
        for (int i = 0; i < NP; i++) desc[i] = {16'($urandom), $urandom};
        desc[1] = 48'h1010_0401_0408;
        for (int i = 0; i < NP; i++) profile_desc[48*i +: 48] = desc[i];

        repeat (2) @(negedge up_clk);
        check("reset outs", {up_wack, up_rack, profile_req, profile_req_sel, profile_sel}, 32'h0);
        check("reset rdata", up_rdata, 32'h0);
        up_rst = 1'b0;

        rd(14'h081, "status");
        rd(14'h080, "cntrl reset");
        rd(14'h090, "desc1 p0");

        wr(14'h080, 32'h1, "sel1");
`ifdef TPL_PROFILE_HANDSHAKE_EN
        ack_after(5, "sel1");
`endif
        rd(14'h090, "desc1 p1");
        rd(14'h091, "desc2 p1");
        check("p1 desc1 const", m_read(14'h090), 32'h0401_0408);

        wr(14'h080, 32'h7, "oob");
        rd(14'h080, "cntrl after oob");

        rd(14'h100, "undecoded rd");
        wr(14'h100, 32'h3, "undecoded wr");

        wr(14'h080, 32'h2, "sel2");
`ifdef TPL_PROFILE_HANDSHAKE_EN
        wr(14'h080, 32'h3, "write in req");
        @(negedge up_clk); profile_ack = 1'b1; up_rreq = 1'b1; up_raddr = 14'h090;
        @(negedge up_clk); profile_ack = 1'b0; up_rreq = 1'b0;
        check("rd at ack old", up_rdata, m_read(14'h090));
        m_psel = m_rsel; m_pend = 1'b0;
        check_profile("ack with rd");
        rd(14'h090, "rd after ack new");
        wr(14'h080, 32'h0, "sel0");
        @(negedge up_clk); up_rst = 1'b1;
        @(negedge up_clk); up_rst = 1'b0;
        model_reset();
        check_profile("reset mid req");
`else
        rd(14'h090, "desc1 p2");
`endif

        @(negedge up_clk);
        up_rreq = 1'b1; up_raddr = 14'h081; up_wreq = 1'b1; up_waddr = 14'h080; up_wdata = 32'h1;
        @(negedge up_clk); up_rreq = 1'b0; up_wreq = 1'b0;
        model_write(14'h080, 32'h1);
        check("simul wack", 32'(up_wack), 32'h1);
        check("simul rack", 32'(up_rack), 32'h1);
        check("simul rdata", up_rdata, 32'h3);
`ifdef TPL_PROFILE_HANDSHAKE_EN
        ack_after(1, "simul");
`endif
        check_profile("simul");

        for (int n = 0; n < 40; n++) begin
            logic [13:0] a;
            a = ($urandom_range(0, 4) == 0) ? 14'($urandom) :
                (14'h080 | 14'($urandom_range(0, 1)) | ($urandom_range(0, 1) ? 14'h010 : 14'h0));
            if ($urandom_range(0, 1) == 1) begin
                wr(a, {$urandom_range(0, 3) == 0 ? 28'($urandom) : 28'h0, 4'($urandom)}, "rand wr");
`ifdef TPL_PROFILE_HANDSHAKE_EN
                if (m_pend) ack_after($urandom_range(0, 4), "rand");
`endif
            end else begin
                rd(a, "rand rd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
